rs_dec_ctrl: RTL and testbench

- Top-level sequencer for the RS(15,9) decoder pipeline, GF(2^4), T2 = 6.
- Runs the four stages in order for each codeword: syndrome calculation, key-equation solver (Berlekamp-Massey), error-value polynomial (Omega), Chien search/Forney.
- Drives a level enable to each stage and waits for that stage's ready.
- Skips the correction stages when all syndromes are zero; enforces a per-stage timeout.
- Provides valid/ready handshakes to the codeword source and to the output sink, plus saturating status counters.

---
 rtl/rs_dec_pkg.sv | 28 ++
 rtl/rs_stage_timer.sv | 27 ++
 rtl/rs_dec_ctrl.sv | 172 +++++++++++++++++
 tb/tb_rs_dec_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rs_dec_pkg.sv
// Shared types and code parameters for the RS(15,9) GF(2^4) decoder controller.
package rs_dec_pkg;

    localparam int WORD_WIDTH = 4;
    localparam int N_NUM      = 15;
    localparam int K_NUM      = 9;
    localparam int T_NUM      = 3;
    localparam int T2_NUM     = 6;

    typedef enum logic [2:0] {
        IDLE,
        SYN,
        KES,
        OMG,
        CHN,
        OUT
    } state_t;

    typedef struct packed {
        logic fail;
        logic tmo;
        logic corr;
    } res_t;

    localparam res_t RES_NONE = '{fail: 1'b0, tmo: 1'b0, corr: 1'b0};
    localparam res_t RES_TMO  = '{fail: 1'b1, tmo: 1'b1, corr: 1'b0};

endpackage

// File: rtl/rs_stage_timer.sv
// Per-stage watchdog: counts cycles while run is high, flags expiry at TIMEOUT_CYC-1.
module rs_stage_timer #(
    parameter int TMO_W       = 6,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expired
);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    assign expired = (cnt == TMO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/rs_dec_ctrl.sv
// Sequencer for the RS(15,9) decoder: syndrome -> key equation -> omega -> Chien/Forney.
// state | meaning
// IDLE  | waiting for a codeword, in_ready high
// SYN   | syndrome stage enabled
// KES   | Berlekamp-Massey stage enabled
// OMG   | error-value polynomial stage enabled
// CHN   | Chien search / Forney stage enabled
// OUT   | result presented until sink handshake
module rs_dec_ctrl
    import rs_dec_pkg::*;
#(
    parameter int TIMEOUT_CYC = 63,
    parameter int CNT_W       = 16,
    parameter int TMO_W       = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             cw_load,
    input  logic             abort,
    output logic             syn_en,
    input  logic             syn_rdy,
    input  logic             syn_zero,
    output logic             kes_en,
    input  logic             kes_rdy,
    output logic             omg_en,
    input  logic             omg_rdy,
    output logic             chn_en,
    input  logic             chn_rdy,
    input  logic             chn_fail,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_fail,
    output logic             out_tmo,
    output logic             out_corr,
    output logic             busy,
    output logic [CNT_W-1:0] cw_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    state_t state;
    res_t   res;
    logic   stg_run;
    logic   stg_rdy;
    logic   expired;

    assign stg_run = (state == SYN) || (state == KES) || (state == OMG) || (state == CHN);

    // A rdy only counts while the matching enable is driven.
    always_comb begin
        stg_rdy = 1'b0;
        case (state)
            SYN:     stg_rdy = syn_rdy & syn_en;
            KES:     stg_rdy = kes_rdy & kes_en;
            OMG:     stg_rdy = omg_rdy & omg_en;
            CHN:     stg_rdy = chn_rdy & chn_en;
            default: stg_rdy = 1'b0;
        endcase
    end

    rs_stage_timer #(
        .TMO_W       (TMO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!stg_run || stg_rdy || abort),
        .run     (stg_run),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            cw_load   <= 1'b0;
            syn_en    <= 1'b0;
            kes_en    <= 1'b0;
            omg_en    <= 1'b0;
            chn_en    <= 1'b0;
            out_valid <= 1'b0;
            res       <= RES_NONE;
            busy      <= 1'b0;
            cw_cnt    <= '0;
            fail_cnt  <= '0;
        end else begin
            cw_load <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                syn_en    <= 1'b0;
                kes_en    <= 1'b0;
                omg_en    <= 1'b0;
                chn_en    <= 1'b0;
                out_valid <= 1'b0;
                res       <= RES_NONE;
                in_ready  <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            state    <= SYN;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            cw_load  <= 1'b1;
                            syn_en   <= 1'b1;
                        end
                    end
                    SYN, KES, OMG, CHN: begin
                        if (stg_rdy) begin
                            case (state)
                                SYN: begin
                                    syn_en <= 1'b0;
                                    if (syn_zero) begin
                                        state     <= OUT;
                                        out_valid <= 1'b1;
                                        res       <= RES_NONE;
                                    end else begin
                                        state  <= KES;
                                        kes_en <= 1'b1;
                                    end
                                end
                                KES: begin
                                    kes_en <= 1'b0;
                                    omg_en <= 1'b1;
                                    state  <= OMG;
                                end
                                OMG: begin
                                    omg_en <= 1'b0;
                                    chn_en <= 1'b1;
                                    state  <= CHN;
                                end
                                default: begin
                                    chn_en    <= 1'b0;
                                    state     <= OUT;
                                    out_valid <= 1'b1;
                                    res       <= '{fail: chn_fail, tmo: 1'b0, corr: !chn_fail};
                                end
                            endcase
                        end else if (expired) begin
                            syn_en    <= 1'b0;
                            kes_en    <= 1'b0;
                            omg_en    <= 1'b0;
                            chn_en    <= 1'b0;
                            state     <= OUT;
                            out_valid <= 1'b1;
                            res       <= RES_TMO;
                        end
                    end
                    OUT: begin
                        if (out_ready) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            res       <= RES_NONE;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            if (cw_cnt != '1) cw_cnt <= cw_cnt + CNT_W'(1);
                            if (res.fail && fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign out_fail = res.fail;
    assign out_tmo  = res.tmo;
    assign out_corr = res.corr;

endmodule

// File: tb/tb_rs_dec_ctrl.sv
// Randomized bench for rs_dec_ctrl with a stage-latency based reference model.
module tb_rs_dec_ctrl;

    localparam int TMO = 63;
    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, abort = 1'b0, syn_rdy = 1'b0, syn_zero = 1'b0;
    logic kes_rdy = 1'b0, omg_rdy = 1'b0, chn_rdy = 1'b0, chn_fail = 1'b0, out_ready = 1'b0;
    logic in_ready, cw_load, syn_en, kes_en, omg_en, chn_en;
    logic out_valid, out_fail, out_tmo, out_corr, busy;
    logic [CW-1:0] cw_cnt, fail_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cw = 0;
    int exp_fl = 0;
    int lat[4];

    always #5 clk = ~clk;

    rs_dec_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(CW), .TMO_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .cw_load(cw_load),
        .abort(abort), .syn_en(syn_en), .syn_rdy(syn_rdy), .syn_zero(syn_zero),
        .kes_en(kes_en), .kes_rdy(kes_rdy), .omg_en(omg_en), .omg_rdy(omg_rdy),
        .chn_en(chn_en), .chn_rdy(chn_rdy), .chn_fail(chn_fail),
        .out_valid(out_valid), .out_ready(out_ready), .out_fail(out_fail), .out_tmo(out_tmo),
        .out_corr(out_corr), .busy(busy), .cw_cnt(cw_cnt), .fail_cnt(fail_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_en"}, {chn_en, omg_en, kes_en, syn_en}, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    // ab_kind: 0 none, 1 abort, 2 reset; fired in the third cycle of stage ab_stage
    task automatic run_cw(input bit zero, input bit cfail, input int hold,
                          input int ab_kind, input int ab_stage, input bit ab_idle);
        int nst, sumd, cyc, nr, ovl, ldbad, n, bad;
        int dur[4], cnt[4], rises[4];
        bit tmo, full, exp_fail, exp_corr, aborting, fired, done;
        logic [3:0] en, r;
        logic [2:0] flags;

        if (ab_kind != 0 && lat[ab_stage] < 3) lat[ab_stage] = 20;
        nst = 0; tmo = 0; sumd = 0;
        for (int s = 0; s < 4; s++) begin dur[s] = 0; cnt[s] = 0; rises[s] = -1; end
        for (int s = 0; s < 4; s++) begin
            if (s == 1 && zero) break;
            dur[s] = (lat[s] >= TMO) ? TMO : lat[s] + 1;
            sumd += dur[s];
            nst++;
            if (lat[s] >= TMO) begin tmo = 1; break; end
        end
        full     = (nst == 4) && !tmo;
        exp_fail = tmo || (full && cfail);
        exp_corr = full && !cfail;
        aborting = (ab_kind != 0) && (ab_stage < nst);

        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("in_ready_before", in_ready, 1);
        syn_zero = zero; chn_fail = cfail; in_valid = 1'b1; abort = ab_idle;
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b0;
        check("cw_load_pulse", cw_load, 1);
        check("syn_en_first", syn_en, 1);
        check("in_ready_busy", in_ready, 0);

        cyc = 0; nr = 0; ovl = 0; ldbad = 0; fired = 0; done = 0;
        while (cyc < 600) begin
            cyc++;
            if (fired) break;
            if (out_valid) begin done = 1; break; end
            if (cyc > 1 && cw_load) ldbad++;
            en = {chn_en, omg_en, kes_en, syn_en};
            if ($countones(en) > 1) ovl++;
            for (int s = 0; s < 4; s++) begin
                if (en[s]) begin
                    cnt[s]++;
                    if (cnt[s] == 1) begin
                        if (nr < 4) rises[nr] = s;
                        nr++;
                    end
                end
            end
            for (int s = 0; s < 4; s++)
                r[s] = en[s] ? (cnt[s] == lat[s] + 1) : ($urandom_range(3) == 0);
            if (aborting && en[ab_stage] && cnt[ab_stage] == 3) begin
                fired = 1;
                r = 4'b0000;
                if (ab_kind == 1) abort = 1'b1;
            end
            {chn_rdy, omg_rdy, kes_rdy, syn_rdy} = r;
            if (fired && ab_kind == 2) begin
                #3 rst_n = 1'b0;
                #1;
                break;
            end
            @(posedge clk); #1;
        end
        {chn_rdy, omg_rdy, kes_rdy, syn_rdy} = 4'b0000;
        abort = 1'b0;

        if (fired && ab_kind == 1) begin
            check_idle("abort");
            check("abort_cw_cnt", cw_cnt, exp_cw);
            check("abort_fail_cnt", fail_cnt, exp_fl);
            return;
        end
        if (fired && ab_kind == 2) begin
            check_idle("rst_async");
            check("rst_cw_load", cw_load, 0);
            check("rst_cw_cnt", cw_cnt, 0);
            check("rst_fail_cnt", fail_cnt, 0);
            exp_cw = 0; exp_fl = 0;
            @(posedge clk); #3 rst_n = 1'b1;
            bad = 0;
            for (int i = 0; i < 4; i++) begin
                {chn_rdy, omg_rdy, kes_rdy, syn_rdy} = 4'b1111;
                @(posedge clk); #1;
                if (busy || !in_ready || {chn_en, omg_en, kes_en, syn_en} != 0 || out_valid) bad++;
            end
            {chn_rdy, omg_rdy, kes_rdy, syn_rdy} = 4'b0000;
            check("spurious_rdy_idle", bad, 0);
            return;
        end
        if (!done) begin
            check("out_valid_wait", 0, 1);
            return;
        end

        check("latency", cyc, sumd + 1);
        for (int s = 0; s < 4; s++) check($sformatf("en_cycles_%0d", s), cnt[s], dur[s]);
        check("en_rise_count", nr, nst);
        for (int i = 0; i < 4; i++) if (i < nst) check($sformatf("en_order_%0d", i), rises[i], i);
        check("en_overlap", ovl, 0);
        check("cw_load_once", ldbad, 0);
        check("out_fail", out_fail, exp_fail);
        check("out_tmo", out_tmo, tmo);
        check("out_corr", out_corr, exp_corr);

        flags = {out_fail, out_tmo, out_corr};
        out_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || {out_fail, out_tmo, out_corr} != flags ||
                cw_cnt != CW'(exp_cw) || fail_cnt != CW'(exp_fl)) bad++;
        end
        check("out_hold_stable", bad, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cw = sat_inc(exp_cw);
        if (exp_fail) exp_fl = sat_inc(exp_fl);
        check_idle("post_out");
        check("post_out_flags", {out_fail, out_tmo, out_corr}, 0);
        check("cw_cnt", cw_cnt, exp_cw);
        check("fail_cnt", fail_cnt, exp_fl);
    endtask

    initial begin
        #12;
        check_idle("reset");
        check("reset_cw_load", cw_load, 0);
        check("reset_flags", {out_fail, out_tmo, out_corr}, 0);
        check("reset_cw_cnt", cw_cnt, 0);
        check("reset_fail_cnt", fail_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        lat = '{1, 0, 0, 0};   run_cw(1, 0, 0, 0, 0, 0);
        lat = '{6, 6, 6, 6};   run_cw(0, 0, 0, 0, 0, 0);
        lat = '{2, 1, 3, 0};   run_cw(0, 1, 10, 0, 0, 0);
        lat = '{0, 70, 0, 0};  run_cw(0, 0, 1, 0, 0, 0);
        lat = '{62, 0, 0, 0};  run_cw(1, 0, 0, 0, 0, 0);
        lat = '{0, 0, 0, 0};   run_cw(0, 0, 0, 0, 0, 0);
        lat = '{0, 0, 20, 0};  run_cw(0, 0, 0, 1, 2, 0);
        lat = '{1, 1, 1, 1};   run_cw(0, 0, 0, 0, 0, 1);
        lat = '{0, 0, 0, 20};  run_cw(0, 0, 0, 2, 3, 0);

        for (int k = 0; k < 40; k++) begin
            int ak, as_;
            for (int s = 0; s < 4; s++) begin
                case ($urandom_range(19))
                    0:       lat[s] = 70;
                    1:       lat[s] = 62;
                    default: lat[s] = $urandom_range(8);
                endcase
            end
            ak  = ($urandom_range(9) == 0) ? 1 : 0;
            as_ = $urandom_range(3);
            run_cw($urandom_range(9) < 3, $urandom_range(9) < 3, $urandom_range(4),
                   ak, as_, $urandom_range(7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
